// File: rtl/seq_serializer.sv
// Parallel-to-serial framer feeding the sequence detector: MSB-first frames with idle gap.
// Define SER_PARITY_EN to append one even-parity bit after the data bits of each frame.
//
// state  | meaning
// IDLE   | din_ready high, waiting for din_valid
// SHIFT  | emitting data bits MSB first, cnt counts remaining bits
// PARITY | emitting the even-parity bit (SER_PARITY_EN only)
// GAP    | GAP_CYCLES idle bit-times, cnt counts remaining gap cycles
module seq_serializer #(
    parameter int WIDTH      = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_done
);

    localparam int CNT_W = 5;

`ifdef SER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, GAP, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

    state_t             state, state_nx;
    logic [WIDTH-1:0]   sreg, sreg_nx;
    logic [CNT_W-1:0]   cnt, cnt_nx;
    logic               take;
    logic               frame_end;
    logic               x_nx, x_valid_nx, frame_done_nx, din_ready_nx;
`ifdef SER_PARITY_EN
    logic               par, par_nx;
`endif

    // din_ready is the registered flag, so the first edge after reset cannot transfer
    assign take = (state == IDLE) && din_ready && din_valid;

    always_comb begin
        state_nx  = state;
        sreg_nx   = sreg;
        cnt_nx    = cnt;
        frame_end = 1'b0;
`ifdef SER_PARITY_EN
        par_nx    = par;
`endif
        case (state)
            IDLE: begin
                if (take) begin
                    sreg_nx  = din;
                    cnt_nx   = CNT_W'(WIDTH - 1);
                    state_nx = SHIFT;
`ifdef SER_PARITY_EN
                    par_nx   = ^din;
`endif
                end
            end
            SHIFT: begin
                sreg_nx = {sreg[WIDTH-2:0], 1'b0};
                if (cnt == '0) begin
`ifdef SER_PARITY_EN
                    state_nx = PARITY;
`else
                    frame_end = 1'b1;
`endif
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                frame_end = 1'b1;
            end
`endif
            GAP: begin
                if (cnt == '0) begin
                    state_nx = IDLE;
                end else begin
                    cnt_nx = cnt - 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        if (frame_end) begin
            if (GAP_CYCLES > 0) begin
                state_nx = GAP;
                cnt_nx   = CNT_W'(GAP_CYCLES) - 1'b1;
            end else begin
                state_nx = IDLE;
            end
        end
    end

    // Outputs are decoded from next-state values and then registered
    always_comb begin
        x_nx          = 1'b0;
        x_valid_nx    = 1'b0;
        frame_done_nx = 1'b0;
        din_ready_nx  = (state_nx == IDLE);
        case (state_nx)
            SHIFT: begin
                x_nx       = sreg_nx[WIDTH-1];
                x_valid_nx = 1'b1;
`ifndef SER_PARITY_EN
                frame_done_nx = (cnt_nx == '0);
`endif
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                x_nx          = par_nx;
                x_valid_nx    = 1'b1;
                frame_done_nx = 1'b1;
            end
`endif
            default: begin
                x_nx = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sreg       <= '0;
            cnt        <= '0;
            x          <= 1'b0;
            x_valid    <= 1'b0;
            frame_done <= 1'b0;
            din_ready  <= 1'b0;
        end else begin
            state      <= state_nx;
            sreg       <= sreg_nx;
            cnt        <= cnt_nx;
            x          <= x_nx;
            x_valid    <= x_valid_nx;
            frame_done <= frame_done_nx;
            din_ready  <= din_ready_nx;
        end
    end

`ifdef SER_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par <= 1'b0;
        end else begin
            par <= par_nx;
        end
    end
`endif

endmodule

// File: tb/tb_seq_serializer.sv
// Bench for seq_serializer: an 8-bit/gap-2 instance and a 4-bit/gap-0 instance checked
// against a frame-level model (bit list MSB first, optional parity, gap, one idle cycle).
`timescale 1ns/1ps
module tb_seq_serializer;

    localparam int W  = 8;
    localparam int G  = 2;
    localparam int WB = 4;
    localparam int GB = 0;
`ifdef SER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]  a_din;
    logic          a_valid, a_ready, a_x, a_xv, a_fd;
    logic [WB-1:0] b_din;
    logic          b_valid, b_ready, b_x, b_xv, b_fd;

    int total = 0;
    int bad   = 0;

    seq_serializer #(.WIDTH(W), .GAP_CYCLES(G)) u_a (
        .clk(clk), .rst(rst), .din(a_din), .din_valid(a_valid), .din_ready(a_ready),
        .x(a_x), .x_valid(a_xv), .frame_done(a_fd)
    );

    seq_serializer #(.WIDTH(WB), .GAP_CYCLES(GB)) u_b (
        .clk(clk), .rst(rst), .din(b_din), .din_valid(b_valid), .din_ready(b_ready),
        .x(b_x), .x_valid(b_xv), .frame_done(b_fd)
    );

    // Entered at a sample point where instance A is idle and ready; returns at the
    // sample point of the idle cycle that ends the frame.
    task automatic a_frame(input logic [W-1:0] w, input logic hold, input logic [W-1:0] nxt);
        logic q[$];
        int   nb, per;
        logic ex, exv, efd, erdy;
        for (int i = W - 1; i >= 0; i--) q.push_back(w[i]);
        if (P == 1) q.push_back(^w);
        nb  = q.size();
        per = nb + G + 1;
        a_din   = w;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = hold;
        for (int k = 1; k <= per; k++) begin
            a_din = (k == per) ? nxt : W'($urandom);
            exv  = (k <= nb);
            ex   = exv ? q[k-1] : 1'b0;
            efd  = (k == nb);
            erdy = (k == per);
            total += 4;
            if (a_x !== ex) begin
                bad++; $display("FAIL a_x word=%h cyc=%0d got=%b want=%b", w, k, a_x, ex);
            end
            if (a_xv !== exv) begin
                bad++; $display("FAIL a_x_valid word=%h cyc=%0d got=%b want=%b", w, k, a_xv, exv);
            end
            if (a_fd !== efd) begin
                bad++; $display("FAIL a_frame_done word=%h cyc=%0d got=%b want=%b", w, k, a_fd, efd);
            end
            if (a_ready !== erdy) begin
                bad++; $display("FAIL a_din_ready word=%h cyc=%0d got=%b want=%b", w, k, a_ready, erdy);
            end
            if (k < per) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic a_idle(input int n);
        a_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            a_din = W'($urandom);
            @(posedge clk); #1;
            total += 3;
            if (a_x !== 1'b0 || a_xv !== 1'b0) begin
                bad++; $display("FAIL a_idle_x cyc=%0d got x=%b v=%b want 0 0", k, a_x, a_xv);
            end
            if (a_fd !== 1'b0) begin
                bad++; $display("FAIL a_idle_fd cyc=%0d got=%b want=0", k, a_fd);
            end
            if (a_ready !== 1'b1) begin
                bad++; $display("FAIL a_idle_ready cyc=%0d got=%b want=1", k, a_ready);
            end
        end
    endtask

    task automatic b_frame(input logic [WB-1:0] w, input logic hold, input logic [WB-1:0] nxt);
        logic q[$];
        int   nb, per;
        logic ex, exv, efd, erdy;
        for (int i = WB - 1; i >= 0; i--) q.push_back(w[i]);
        if (P == 1) q.push_back(^w);
        nb  = q.size();
        per = nb + GB + 1;
        b_din   = w;
        b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = hold;
        for (int k = 1; k <= per; k++) begin
            b_din = (k == per) ? nxt : WB'($urandom);
            exv  = (k <= nb);
            ex   = exv ? q[k-1] : 1'b0;
            efd  = (k == nb);
            erdy = (k == per);
            total += 4;
            if (b_x !== ex) begin
                bad++; $display("FAIL b_x word=%h cyc=%0d got=%b want=%b", w, k, b_x, ex);
            end
            if (b_xv !== exv) begin
                bad++; $display("FAIL b_x_valid word=%h cyc=%0d got=%b want=%b", w, k, b_xv, exv);
            end
            if (b_fd !== efd) begin
                bad++; $display("FAIL b_frame_done word=%h cyc=%0d got=%b want=%b", w, k, b_fd, efd);
            end
            if (b_ready !== erdy) begin
                bad++; $display("FAIL b_din_ready word=%h cyc=%0d got=%b want=%b", w, k, b_ready, erdy);
            end
            if (k < per) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        total += 8;
        if (a_x !== 1'b0)      begin bad++; $display("FAIL rst_a_x got=%b want=0", a_x); end
        if (a_xv !== 1'b0)     begin bad++; $display("FAIL rst_a_xv got=%b want=0", a_xv); end
        if (a_fd !== 1'b0)     begin bad++; $display("FAIL rst_a_fd got=%b want=0", a_fd); end
        if (a_ready !== 1'b0)  begin bad++; $display("FAIL rst_a_ready got=%b want=0", a_ready); end
        if (b_x !== 1'b0)      begin bad++; $display("FAIL rst_b_x got=%b want=0", b_x); end
        if (b_xv !== 1'b0)     begin bad++; $display("FAIL rst_b_xv got=%b want=0", b_xv); end
        if (b_fd !== 1'b0)     begin bad++; $display("FAIL rst_b_fd got=%b want=0", b_fd); end
        if (b_ready !== 1'b0)  begin bad++; $display("FAIL rst_b_ready got=%b want=0", b_ready); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        total += 2;
        if (a_ready !== 1'b1) begin bad++; $display("FAIL rel_a_ready got=%b want=1", a_ready); end
        if (b_ready !== 1'b1) begin bad++; $display("FAIL rel_b_ready got=%b want=1", b_ready); end
    endtask

    task automatic test_directed();
        a_frame(8'hA5, 1'b1, 8'h3C);
        a_frame(8'h3C, 1'b0, 8'h00);
        a_idle(3);
        a_frame(8'h07, 1'b0, 8'h00);
        a_idle(1);
        a_frame(8'h00, 1'b1, 8'hFF);
        a_frame(8'hFF, 1'b0, 8'h00);
        a_idle(2);
    endtask

    task automatic test_random();
        logic [W-1:0] w, nxt;
        logic         h;
        w = W'($urandom);
        for (int j = 0; j < 20; j++) begin
            nxt = W'($urandom);
            h   = 1'($urandom_range(0, 1));
            a_frame(w, h, nxt);
            if (!h) a_idle($urandom_range(0, 2));
            w = nxt;
        end
        a_valid = 1'b0;
        a_idle(2);
    endtask

    task automatic test_reset_midframe();
        a_din   = 8'hFF;
        a_valid = 1'b1;
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (a_x !== 1'b1 || a_xv !== 1'b1) begin
            bad++; $display("FAIL mid_bit3 got x=%b v=%b want 1 1", a_x, a_xv);
        end
        #2;
        rst = 1'b0;
        #1;
        total += 4;
        if (a_x !== 1'b0)     begin bad++; $display("FAIL mid_rst_x got=%b want=0", a_x); end
        if (a_xv !== 1'b0)    begin bad++; $display("FAIL mid_rst_xv got=%b want=0", a_xv); end
        if (a_fd !== 1'b0)    begin bad++; $display("FAIL mid_rst_fd got=%b want=0", a_fd); end
        if (a_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", a_ready); end
        @(posedge clk); #1;
        total++;
        if (a_ready !== 1'b0 || a_xv !== 1'b0) begin
            bad++; $display("FAIL mid_hold got ready=%b v=%b want 0 0", a_ready, a_xv);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        total++;
        if (a_ready !== 1'b1) begin bad++; $display("FAIL mid_rel_ready got=%b want=1", a_ready); end
        a_idle(15);
    endtask

    task automatic test_gap0();
        logic [WB-1:0] w, nxt;
        b_frame(4'b1011, 1'b1, 4'b1011);
        b_frame(4'b1011, 1'b1, 4'b1011);
        b_frame(4'b1011, 1'b1, 4'b0110);
        w = 4'b0110;
        for (int j = 0; j < 8; j++) begin
            nxt = WB'($urandom);
            b_frame(w, 1'b1, nxt);
            w = nxt;
        end
        b_frame(w, 1'b0, 4'h0);
        b_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if (b_xv !== 1'b0 || b_x !== 1'b0 || b_ready !== 1'b1) begin
                bad++; $display("FAIL b_idle cyc=%0d got v=%b x=%b rdy=%b want 0 0 1", k, b_xv, b_x, b_ready);
            end
        end
    endtask

    initial begin
        a_din = '0; a_valid = 1'b0;
        b_din = '0; b_valid = 1'b0;
        test_reset();
        test_directed();
        test_random();
        test_reset_midframe();
        test_gap0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, giving the number of data bits per frame (legal range 2..32).
REQ-002 SHALL provide parameter GAP_CYCLES, default 2, giving the idle bit-times inserted after each frame (legal range 0..15).
REQ-003 SHALL provide port clk  input  1  single system clock, all state changes on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port din  input  WIDTH  parallel word to serialize.
REQ-006 SHALL provide port din_valid  input  1  producer offers din.
REQ-007 SHALL provide port din_ready  output  1  block can accept din this cycle.
REQ-008 SHALL provide port x  output  1  serial bit stream feeding the downstream sequence detector input.
REQ-009 SHALL provide port x_valid  output  1  x carries a frame bit this cycle.
REQ-010 SHALL provide port frame_done  output  1  one-cycle pulse on the last bit of a frame.

Function
REQ-011 SHALL implement states IDLE, SHIFT, PARITY and GAP; PARITY exists only under REQ-027.
REQ-012 SHALL drive din_ready=1 only in IDLE; a transfer occurs on a rising edge with din_valid=1 and din_ready=1.
REQ-013 On transfer SHALL capture din into a WIDTH-bit shift register, load the bit counter with WIDTH-1, and enter SHIFT.
REQ-014 SHALL ignore din and din_valid in every state other than IDLE; no buffering of a second word.
REQ-015 In SHIFT SHALL drive x = shift register MSB and x_valid=1; the first data bit appears the cycle after the transfer (latency 1).
REQ-016 Each SHIFT cycle SHALL shift the register left by one and decrement the counter; MSB-first order.
REQ-017 SHIFT with counter==0 SHALL transition to PARITY if compiled in, else to GAP if GAP_CYCLES>0, else to IDLE.
REQ-018 GAP SHALL last exactly GAP_CYCLES cycles with x=0 and x_valid=0, then transition to IDLE.
REQ-019 In IDLE and GAP SHALL hold x=0 and x_valid=0.
REQ-020 SHALL assert frame_done for exactly one cycle, coincident with the final transmitted bit of the frame (last data bit, or the parity bit when compiled in).
REQ-021 All outputs SHALL be registered; no combinational path from din or din_valid to any output.
REQ-022 With din_valid held high, frame period SHALL be WIDTH + P + GAP_CYCLES + 1 cycles, where P=1 with parity and 0 without.

Reset
REQ-023 Assertion of rst (low) SHALL immediately force state IDLE, shift register 0, counter 0, x=0, x_valid=0, frame_done=0.
REQ-024 While rst is low, din_ready SHALL be 0; after deassertion, din_ready SHALL be 1 from the first rising edge.
REQ-025 Reset mid-frame SHALL discard the partial frame; no remaining bits, parity or gap SHALL be emitted afterwards.
REQ-026 SHALL produce no X on any output after reset for any din value.

Configuration
REQ-027 Macro SER_PARITY_EN, when defined, SHALL add the PARITY state: one cycle with x = XOR of the captured WIDTH data bits (even parity), x_valid=1, then GAP or IDLE per REQ-017.
REQ-028 Without SER_PARITY_EN, SHALL contain no parity logic and no PARITY state; frames are WIDTH bits exactly.

Verification
REQ-029 Reset released, din=8'hA5 with valid for one cycle -> x = 1,0,1,0,0,1,0,1 on cycles 1..8 after transfer, x_valid high for those 8 cycles, frame_done on cycle 8, din_ready back high on cycle 11 (GAP_CYCLES=2).
REQ-030 din_valid held high with 8'hA5 then 8'h3C -> second transfer exactly 11 cycles after the first; no x_valid during the 2 gap cycles.
REQ-031 rst pulsed low after 3 bits of 8'hFF -> x=0, x_valid=0 immediately; after release din_ready=1 and no residual 1s on x.
REQ-032 SER_PARITY_EN defined: 8'hA5 -> 9th bit 0; 8'h07 -> 9th bit 1; frame_done on the 9th bit.
REQ-033 GAP_CYCLES=0, WIDTH=4, continuous valid with 4'b1011 -> x_valid low exactly one cycle (IDLE) between frames, period 5 cycles.
